// File: rtl/pattern_detect_pkg.sv
// pattern_detect_pkg: shared types and default sizing for the programmable
// bit-serial pattern detector.
//   state_e    : controller states (IDLE, ARMED, DONE)
//   MAX_LEN_D  : default maximum pattern length in bits
//   LEN_W_D    : default width of the length field (must hold MAX_LEN)
//   CNT_W_D    : default width of the match counter / target
package pattern_detect_pkg;
  localparam int MAX_LEN_D = 8;
  localparam int LEN_W_D   = 4;
  localparam int CNT_W_D   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/pattern_detect_ctrl_if.sv
// pattern_detect_ctrl_if: configuration handshake bundle.
//   cfg_valid/cfg_ready : config offer / accept
//   cfg_pattern         : pattern, bit 0 = most recent bit
//   cfg_len             : pattern length (legal 1..MAX_LEN)
//   cfg_target          : matches to reach DONE, 0 = unlimited
//   cfg_err             : one-cycle pulse after an illegal length was offered
// master = host side, slave = detector side.
interface pattern_detect_ctrl_if
  import pattern_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_D,
  parameter int LEN_W   = LEN_W_D,
  parameter int CNT_W   = CNT_W_D
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;

  modport master (output cfg_valid, cfg_pattern, cfg_len, cfg_target,
                  input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_pattern, cfg_len, cfg_target,
                  output cfg_ready, cfg_err);
endinterface

// File: rtl/pattern_shift_cmp.sv
// pattern_shift_cmp: history shift register, saturating fill counter and
// length-masked pattern compare.
//   clr      : clear history and fill (new scan)
//   shift_en : sample datain into history bit 0 this edge
//   pattern  : loaded pattern, len : loaded length
//   hit      : this edge's sample completes a match (combinational, looks at
//              the post-shift history so the owner can register a pulse)
// Build option PATTERN_DETECT_CTRL_OVERLAP_EN: when defined, a match leaves
// the fill count alone so matches may overlap; otherwise fill restarts from
// zero after each match.
module pattern_shift_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               datain,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);
  logic [MAX_LEN-1:0] hist_q, hist_nxt, mask;
  logic [MAX_LEN:0]   hist_wide;
  logic [LEN_W-1:0]   fill_q, fill_nxt;

  always_comb begin
    hist_wide = {hist_q, datain};
    hist_nxt  = hist_wide[MAX_LEN-1:0];
    fill_nxt  = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
    hit = shift_en && (fill_nxt >= len) && (((hist_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_nxt;
`ifdef PATTERN_DETECT_CTRL_OVERLAP_EN
      fill_q <= fill_nxt;
`else
      // next match must be built entirely from fresh bits
      fill_q <= hit ? '0 : fill_nxt;
`endif
    end
  end
endmodule

// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl: programmable bit-serial pattern detection controller.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg          : configuration handshake (pattern_detect_ctrl_if.slave)
//   start, abort : arm the scan / return to IDLE (abort has priority)
//   datain       : serial bit, qualified by din_valid
//   match        : one-cycle pulse per detected match
//   match_count  : matches since last start, saturating
//   busy / done  : high in ARMED / DONE
// Build option PATTERN_DETECT_CTRL_OVERLAP_EN selects overlapping matches
// (handled inside pattern_shift_cmp).
module pattern_detect_ctrl
  import pattern_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_D,
  parameter int LEN_W   = LEN_W_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pattern_detect_ctrl_if.slave  cfg,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  datain,
  input  logic                  din_valid,
  output logic                  match,
  output logic [CNT_W-1:0]      match_count,
  output logic                  busy,
  output logic                  done
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ARMED = ARMED;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]         state_q;
  logic               loaded_q, match_q, err_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_inc;
  logic               len_ok, scan_clr, shift_en, hit;

  assign len_ok   = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(MAX_LEN));
  // DONE implies a config exists, so loaded_q gates both IDLE and DONE starts
  assign scan_clr = !abort && start && loaded_q && (state_q != S_ARMED);
  assign shift_en = (state_q == S_ARMED) && din_valid && !abort;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  pattern_shift_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (scan_clr),
    .shift_en (shift_en),
    .datain   (datain),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      loaded_q <= 1'b0;
      pat_q    <= '0;
      len_q    <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      match_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == S_IDLE && cfg.cfg_valid) begin
        if (len_ok) begin
          loaded_q <= 1'b1;
          pat_q    <= cfg.cfg_pattern;
          len_q    <= cfg.cfg_len;
          tgt_q    <= cfg.cfg_target;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (abort) begin
        state_q <= S_IDLE;
      end else if (scan_clr) begin
        state_q <= S_ARMED;
        cnt_q   <= '0;
      end else if (hit) begin
        // hit is only possible while ARMED
        match_q <= 1'b1;
        cnt_q   <= cnt_inc;
        if (tgt_q != '0 && cnt_inc == tgt_q) state_q <= S_DONE;
      end else if (state_q != S_IDLE && state_q != S_ARMED && state_q != S_DONE) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign cfg.cfg_ready = (state_q == S_IDLE);
  assign cfg.cfg_err   = err_q;
  assign match         = match_q;
  assign match_count   = cnt_q;
  assign busy          = (state_q == S_ARMED);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Testbench for pattern_detect_ctrl: directed scenarios plus a randomized
// phase, every cycle compared against a queue-based reference model.
module tb_pattern_detect_ctrl;
  import pattern_detect_pkg::*;
  localparam int ML = 8, LW = 4, CW = 8;
`ifdef PATTERN_DETECT_CTRL_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, datain, din_valid, match, busy, done;
  logic [CW-1:0] match_count;
  always #5 clk = ~clk;

  pattern_detect_ctrl_if #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) cfg_bus ();

  pattern_detect_ctrl #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_bus), .start(start), .abort(abort),
    .datain(datain), .din_valid(din_valid), .match(match),
    .match_count(match_count), .busy(busy), .done(done)
  );

  int checks = 0, errors = 0;

  // reference model: bits seen since the scan (or last non-overlap match)
  bit          m_loaded;
  bit [ML-1:0] m_pat;
  int          m_len, m_tgt, m_cnt;
  state_e      m_st;
  bit          m_match, m_err;
  bit          m_hist[$];

  function automatic void model_reset();
    m_loaded = 0; m_st = IDLE; m_cnt = 0; m_match = 0; m_err = 0;
    m_pat = '0; m_len = 0; m_tgt = 0; m_hist.delete();
  endfunction

  function automatic bit tail_matches();
    int n = m_hist.size();
    if (n < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (m_hist[n-1-i] != m_pat[i]) return 0;
    return 1;
  endfunction

  function automatic void model_edge();
    bit was_loaded = m_loaded;
    m_match = 0; m_err = 0;
    if (m_st == IDLE && cfg_bus.cfg_valid) begin
      if (cfg_bus.cfg_len >= 1 && int'(cfg_bus.cfg_len) <= ML) begin
        m_loaded = 1; m_pat = cfg_bus.cfg_pattern;
        m_len = int'(cfg_bus.cfg_len); m_tgt = int'(cfg_bus.cfg_target);
      end else m_err = 1;
    end
    if (abort) m_st = IDLE;
    else if (m_st == ARMED) begin
      if (din_valid) begin
        m_hist.push_back(datain);
        if (m_hist.size() > ML) void'(m_hist.pop_front());
        if (tail_matches()) begin
          m_match = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          if (!OVL) m_hist.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) m_st = DONE;
        end
      end
    end else if (start && was_loaded) begin
      m_st = ARMED; m_cnt = 0; m_hist.delete();
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("cfg_ready",   32'(cfg_bus.cfg_ready), 32'(m_st == IDLE));
    chk("busy",        32'(busy),              32'(m_st == ARMED));
    chk("done",        32'(done),              32'(m_st == DONE));
    chk("match",       32'(match),             32'(m_match));
    chk("cfg_err",     32'(cfg_bus.cfg_err),   32'(m_err));
    chk("match_count", 32'(match_count),       32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    start = 0; abort = 0; din_valid = 0; datain = 0; cfg_bus.cfg_valid = 0;
  endtask

  task automatic do_cfg(logic [ML-1:0] p, logic [LW-1:0] l, logic [CW-1:0] t);
    cfg_bus.cfg_valid = 1; cfg_bus.cfg_pattern = p;
    cfg_bus.cfg_len = l; cfg_bus.cfg_target = t;
    tick();
  endtask

  task automatic do_start(); start = 1; tick(); endtask
  task automatic do_abort(); abort = 1; tick(); endtask
  task automatic send_bit(logic b); din_valid = 1; datain = b; tick(); endtask

  initial begin
    int mc, done_idx;
    logic [9:0] s3;
    rst_n = 0; start = 0; abort = 0; datain = 0; din_valid = 0;
    cfg_bus.cfg_valid = 0; cfg_bus.cfg_pattern = '0;
    cfg_bus.cfg_len = '0; cfg_bus.cfg_target = '0;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1;

    // start with nothing loaded is ignored
    do_start();
    chk("noconfig_start_busy", 32'(busy), 32'd0);

    // 101 against 1010101
    do_cfg(8'b101, 4'd3, 8'd0);
    do_start();
    mc = 0;
    for (int i = 0; i < 7; i++) begin send_bit(i[0] ? 1'b0 : 1'b1); mc += int'(match); end
    chk("t1_match_pulses", 32'(mc), OVL ? 32'd3 : 32'd2);
    chk("t1_count", 32'(match_count), OVL ? 32'd3 : 32'd2);
    do_abort();

    // 1101 target 2 against 1101101101 (first bit sent first)
    do_cfg(8'b1101, 4'd4, 8'd2);
    do_start();
    s3 = 10'b1101101101;
    done_idx = -1;
    for (int i = 0; i < 10; i++) begin
      send_bit(s3[9-i]);
      if (done && done_idx < 0) begin
        done_idx = i;
        chk("t2_done_with_match", 32'(match), 32'd1);
        chk("t2_busy_fall", 32'(busy), 32'd0);
      end
    end
    chk("t2_done_idx", 32'(done_idx), OVL ? 32'd6 : 32'd9);
    chk("t2_count", 32'(match_count), 32'd2);
    chk("t2_done", 32'(done), 32'd1);
    do_abort();

    // illegal lengths keep the old 1101 config
    do_cfg(8'hFF, 4'd0, 8'd0);
    chk("err_len0", 32'(cfg_bus.cfg_err), 32'd1);
    tick();
    chk("err_len0_pulse_end", 32'(cfg_bus.cfg_err), 32'd0);
    do_cfg(8'hFF, 4'd9, 8'd0);
    chk("err_len9", 32'(cfg_bus.cfg_err), 32'd1);
    do_start();
    send_bit(1); send_bit(1); send_bit(0); send_bit(1);
    chk("old_cfg_match", 32'(match), 32'd1);
    do_abort();

    // abort in the cycle a match completes
    do_cfg(8'b101, 4'd3, 8'd0);
    do_start();
    send_bit(1); send_bit(0); send_bit(1);
    send_bit(1); send_bit(0);
    din_valid = 1; datain = 1; abort = 1; tick();
    chk("abort_no_match", 32'(match), 32'd0);
    chk("abort_count_held", 32'(match_count), 32'd1);
    chk("abort_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    // din_valid gaps inside the pattern
    do_start();
    send_bit(1); tick(); send_bit(0); tick(); send_bit(1);
    chk("gap_match", 32'(match), 32'd1);
    tick();
    chk("gap_match_pulse_end", 32'(match), 32'd0);
    chk("gap_count", 32'(match_count), 32'd1);
    do_abort();

    // asynchronous reset while ARMED with count 5
    do_cfg(8'b1, 4'd1, 8'd0);
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1);
    chk("pre_rst_count", 32'(match_count), 32'd5);
    #2 rst_n = 0;
    #1 model_reset();
    check_outputs();
    chk("rst_count", 32'(match_count), 32'd0);
    #2 rst_n = 1;
    do_start();
    chk("rst_start_ignored", 32'(busy), 32'd0);
    do_cfg(8'b1, 4'd1, 8'd0);
    do_start();
    chk("rst_reload_start", 32'(busy), 32'd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 8) begin
        cfg_bus.cfg_valid = 1;
        cfg_bus.cfg_pattern = ML'($urandom);
        cfg_bus.cfg_len = LW'($urandom_range(0, 9));
        cfg_bus.cfg_target = CW'($urandom_range(0, 3));
      end
      start = (r >= 8 && r < 20);
      abort = (r >= 97);
      din_valid = ($urandom_range(0, 3) != 0);
      datain = $urandom_range(0, 1) != 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
